// File: rtl/ptmch_trg_pkg.sv
// ---------------------------------------------------------------------------
// ptmch_trg_pkg
// Shared constants and types for the SPI-programmed trigger sequencer:
//   - SPI frame geometry (32-bit frame: OPC[31:24], ADDR[23:16], DATA[15:0])
//   - command opcodes
//   - per-channel sequencer state enum
// ---------------------------------------------------------------------------
package ptmch_trg_pkg;

    // Frame geometry
    localparam int FRAME_W   = 32;
    localparam int BIT_CNT_W = $clog2(FRAME_W + 1);
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 24;
    localparam int ADDR_MSB  = 23;
    localparam int ADDR_LSB  = 16;
    localparam int DATA_MSB  = 15;
    localparam int DATA_LSB  = 0;

    // Command opcodes
    localparam logic [7:0] OPC_DELAY  = 8'h01;
    localparam logic [7:0] OPC_WIDTH  = 8'h02;
    localparam logic [7:0] OPC_ENABLE = 8'h03;
    localparam logic [7:0] OPC_PERIOD = 8'h04;
    localparam logic [7:0] OPC_MODE   = 8'h05;
    localparam logic [7:0] OPC_FIRE   = 8'h10;
    localparam logic [7:0] OPC_ABORT  = 8'h11;

    // Per-channel sequencer state
    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_DLY  = 2'd1,
        CH_PLS  = 2'd2
    } ch_state_e;

endpackage

// File: rtl/ptmch_spi_rx.sv
// ---------------------------------------------------------------------------
// ptmch_spi_rx
// SPI mode-0 slave receiver running entirely in the system clock domain.
// SPI inputs are brought in through 2-flop synchronisers; the SPI clock
// rising edge is detected on the synchronised copy and one MOSI bit is
// shifted per edge while CS is low. The 32nd bit produces a one-cycle
// frame_valid strobe with the full word; extra bits in the same CS-low
// period are ignored. CS rising with 1..31 bits collected pulses frame_err.
//
// Ports
//   clk         system clock
//   srst        synchronous active-high reset
//   spi_cs      SPI chip select, active low, asynchronous
//   spi_clk     SPI clock, asynchronous
//   spi_mosi    SPI data, MSB first
//   frame_valid one-cycle strobe: frame_word holds a complete frame
//   frame_word  received 32-bit frame
//   frame_err   one-cycle strobe on a truncated frame
// ---------------------------------------------------------------------------
module ptmch_spi_rx
    import ptmch_trg_pkg::*;
(
    input  logic               clk,
    input  logic               srst,
    input  logic               spi_cs,
    input  logic               spi_clk,
    input  logic               spi_mosi,
    output logic               frame_valid,
    output logic [FRAME_W-1:0] frame_word,
    output logic               frame_err
);

    localparam logic [BIT_CNT_W-1:0] FULL_CNT = BIT_CNT_W'(FRAME_W);
    localparam logic [BIT_CNT_W-1:0] LAST_CNT = BIT_CNT_W'(FRAME_W - 1);

    logic [1:0]           cs_sync_reg;
    logic [1:0]           sclk_sync_reg;
    logic [1:0]           mosi_sync_reg;
    logic                 sclk_d_reg;
    logic                 cs_s;
    logic                 sclk_s;
    logic                 mosi_s;
    logic                 sclk_rise;

    logic                 armed_reg,       armed_next;
    logic [FRAME_W-1:0]   shift_reg,       shift_next;
    logic [BIT_CNT_W-1:0] bit_cnt_reg,     bit_cnt_next;
    logic                 frame_valid_reg, frame_valid_next;
    logic                 frame_err_reg,   frame_err_next;

    assign cs_s      = cs_sync_reg[1];
    assign sclk_s    = sclk_sync_reg[1];
    assign mosi_s    = mosi_sync_reg[1];
    assign sclk_rise = sclk_s & ~sclk_d_reg;

    // The CS synchroniser resets to 0 (not the idle 1) on purpose: the
    // receiver only arms after it has really seen CS high, so a reset that
    // lands in the middle of a frame drops the remainder of that frame
    // instead of resyncing onto its tail bits.
    always_ff @(posedge clk) begin
        if (srst) begin
            cs_sync_reg     <= 2'b00;
            sclk_sync_reg   <= 2'b00;
            mosi_sync_reg   <= 2'b00;
            sclk_d_reg      <= 1'b0;
            armed_reg       <= 1'b0;
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            cs_sync_reg     <= {cs_sync_reg[0], spi_cs};
            sclk_sync_reg   <= {sclk_sync_reg[0], spi_clk};
            mosi_sync_reg   <= {mosi_sync_reg[0], spi_mosi};
            sclk_d_reg      <= sclk_s;
            armed_reg       <= armed_next;
            shift_reg       <= shift_next;
            bit_cnt_reg     <= bit_cnt_next;
            frame_valid_reg <= frame_valid_next;
            frame_err_reg   <= frame_err_next;
        end
    end

    always_comb begin
        armed_next       = armed_reg;
        shift_next       = shift_reg;
        bit_cnt_next     = bit_cnt_reg;
        frame_valid_next = 1'b0;
        frame_err_next   = 1'b0;
        if (cs_s) begin
            // Deselected: arm for the next frame and flag a short one.
            armed_next   = 1'b1;
            bit_cnt_next = '0;
            if ((bit_cnt_reg != '0) && (bit_cnt_reg < FULL_CNT)) begin
                frame_err_next = 1'b1;
            end
        end else if (armed_reg && sclk_rise && (bit_cnt_reg < FULL_CNT)) begin
            shift_next   = {shift_reg[FRAME_W-2:0], mosi_s};
            bit_cnt_next = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == LAST_CNT) begin
                frame_valid_next = 1'b1;
            end
        end
    end

    assign frame_valid = frame_valid_reg;
    assign frame_word  = shift_reg;
    assign frame_err   = frame_err_reg;

endmodule

// File: rtl/ptmch_trg_seq.sv
// ---------------------------------------------------------------------------
// ptmch_trg_seq
// SPI-programmed multi-channel trigger pulse sequencer. Configuration
// (per-channel DELAY/WIDTH, ENABLE mask, PERIOD, MODE) is written through
// 32-bit SPI frames. FIRE snapshots the configuration into shadow
// registers and starts one small FSM per channel (IDLE -> DLY -> PLS ->
// IDLE). In repeat mode with a non-zero period all enabled channels are
// restarted every PERIOD cycles until ABORT.
//
// Ports
//   CLK160M    sole clock
//   RESET      synchronous active-high reset
//   SPI_CS     SPI chip select (active low, asynchronous)
//   SPI_CLK    SPI clock (mode 0, asynchronous)
//   SPI_MOSI   SPI data, MSB first
//   TRG_PLS    registered trigger pulses, one bit per channel
//   BUSY       high while a sequence is active
//   FRAME_ERR  one-cycle strobe on a truncated SPI frame
// ---------------------------------------------------------------------------
module ptmch_trg_seq
    import ptmch_trg_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK160M,
    input  logic              RESET,
    input  logic              SPI_CS,
    input  logic              SPI_CLK,
    input  logic              SPI_MOSI,
    output logic [NUM_CH-1:0] TRG_PLS,
    output logic              BUSY,
    output logic              FRAME_ERR
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Resize the 16-bit frame payload to the counter width: truncation when
    // CNT_W is narrower, zero extension when it is wider.
    function automatic logic [CNT_W-1:0] fit_data(input logic [15:0] d);
        logic [CNT_W+15:0] ext;
        ext = {{CNT_W{1'b0}}, d};
        return ext[CNT_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // SPI receiver
    // ------------------------------------------------------------------
    logic               frame_valid;
    logic [FRAME_W-1:0] frame_word;

    ptmch_spi_rx u_spi_rx (
        .clk         (CLK160M),
        .srst        (RESET),
        .spi_cs      (SPI_CS),
        .spi_clk     (SPI_CLK),
        .spi_mosi    (SPI_MOSI),
        .frame_valid (frame_valid),
        .frame_word  (frame_word),
        .frame_err   (FRAME_ERR)
    );

    // ------------------------------------------------------------------
    // Frame decode
    // ------------------------------------------------------------------
    logic [7:0]       opc;
    logic [7:0]       addr;
    logic [CNT_W-1:0] data_fit;
    logic             wr_delay;
    logic             wr_width;
    logic             wr_enable;
    logic             wr_period;
    logic             wr_mode;
    logic             fire_accept;
    logic             abort_cmd;

    assign opc      = frame_word[OPC_MSB:OPC_LSB];
    assign addr     = frame_word[ADDR_MSB:ADDR_LSB];
    assign data_fit = fit_data(frame_word[DATA_MSB:DATA_LSB]);

    assign wr_delay  = frame_valid && (opc == OPC_DELAY);
    assign wr_width  = frame_valid && (opc == OPC_WIDTH);
    assign wr_enable = frame_valid && (opc == OPC_ENABLE);
    assign wr_period = frame_valid && (opc == OPC_PERIOD);
    assign wr_mode   = frame_valid && (opc == OPC_MODE);
    assign abort_cmd = frame_valid && (opc == OPC_ABORT);

    // ------------------------------------------------------------------
    // Global configuration, shadows and period timer
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] enable_reg;
    logic [NUM_CH-1:0] enable_sh_reg;
    logic [CNT_W-1:0]  period_reg;
    logic [CNT_W-1:0]  period_sh_reg;
    logic              mode_reg;
    logic              mode_sh_reg;
    logic [CNT_W-1:0]  per_cnt_reg, per_cnt_next;
    logic              busy_reg,    busy_next;
    logic              repeat_on;
    logic              restart;
    logic              start;
    logic [NUM_CH-1:0] ch_active_next;

    assign fire_accept = frame_valid && (opc == OPC_FIRE) && !busy_reg;

    // Repeat mode with PERIOD=0 falls through to single-shot behaviour.
    assign repeat_on = busy_reg && mode_sh_reg && (period_sh_reg != '0);
    assign restart   = repeat_on && (per_cnt_reg == CNT_ONE) && !abort_cmd;
    assign start     = fire_accept || restart;

    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            enable_reg    <= '0;
            enable_sh_reg <= '0;
            period_reg    <= '0;
            period_sh_reg <= '0;
            mode_reg      <= 1'b0;
            mode_sh_reg   <= 1'b0;
            per_cnt_reg   <= '0;
            busy_reg      <= 1'b0;
        end else begin
            if (wr_enable) begin
                enable_reg <= frame_word[NUM_CH-1:0];
            end
            if (wr_period) begin
                period_reg <= data_fit;
            end
            if (wr_mode) begin
                mode_reg <= frame_word[0];
            end
            if (fire_accept) begin
                enable_sh_reg <= enable_reg;
                period_sh_reg <= period_reg;
                mode_sh_reg   <= mode_reg;
            end
            per_cnt_reg <= per_cnt_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        per_cnt_next = per_cnt_reg;
        if (abort_cmd) begin
            per_cnt_next = '0;
        end else if (fire_accept) begin
            per_cnt_next = period_reg;
        end else if (restart) begin
            per_cnt_next = period_sh_reg;
        end else if (repeat_on && (per_cnt_reg != '0)) begin
            per_cnt_next = per_cnt_reg - CNT_ONE;
        end
    end

    // BUSY is asserted the cycle after an accepted FIRE and, in single
    // mode, drops together with the last channel going back to IDLE.
    always_comb begin
        busy_next = |ch_active_next;
        if (abort_cmd) begin
            busy_next = 1'b0;
        end else if (fire_accept || repeat_on) begin
            busy_next = 1'b1;
        end
    end

    assign BUSY = busy_reg;

    // ------------------------------------------------------------------
    // Per-channel configuration and sequencer FSM
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] delay_reg;
            logic [CNT_W-1:0] width_reg;
            logic [CNT_W-1:0] delay_sh_reg;
            logic [CNT_W-1:0] width_sh_reg;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic [CNT_W-1:0] ld_delay;
            logic [CNT_W-1:0] ld_width;
            logic             ld_en;
            logic             ch_sel;
            logic             pls_reg;
            ch_state_e        state_reg, state_next;

            // Addresses at or above NUM_CH never match any channel.
            assign ch_sel = (addr == 8'(gi));

            always_ff @(posedge CLK160M) begin
                if (RESET) begin
                    delay_reg    <= '0;
                    width_reg    <= '0;
                    delay_sh_reg <= '0;
                    width_sh_reg <= '0;
                    cnt_reg      <= '0;
                    state_reg    <= CH_IDLE;
                    pls_reg      <= 1'b0;
                end else begin
                    if (wr_delay && ch_sel) begin
                        delay_reg <= data_fit;
                    end
                    if (wr_width && ch_sel) begin
                        width_reg <= data_fit;
                    end
                    if (fire_accept) begin
                        delay_sh_reg <= delay_reg;
                        width_sh_reg <= width_reg;
                    end
                    cnt_reg   <= cnt_next;
                    state_reg <= state_next;
                    pls_reg   <= (state_next == CH_PLS);
                end
            end

            // On FIRE the live values are the ones being snapshotted; on a
            // periodic restart the shadows are authoritative.
            always_comb begin
                ld_delay = fire_accept ? delay_reg       : delay_sh_reg;
                ld_width = fire_accept ? width_reg       : width_sh_reg;
                ld_en    = fire_accept ? enable_reg[gi]  : enable_sh_reg[gi];
            end

            // cnt_reg holds the cycles remaining in the current phase,
            // including the present one. Down-counting from the loaded value
            // means the full DELAY+WIDTH range is reachable and the counter
            // can never wrap.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                if (abort_cmd) begin
                    state_next = CH_IDLE;
                    cnt_next   = '0;
                end else if (start) begin
                    // A restart also cuts off a pulse that is still high.
                    if (!ld_en) begin
                        state_next = CH_IDLE;
                        cnt_next   = '0;
                    end else if (ld_delay != '0) begin
                        state_next = CH_DLY;
                        cnt_next   = ld_delay;
                    end else if (ld_width != '0) begin
                        state_next = CH_PLS;
                        cnt_next   = ld_width;
                    end else begin
                        state_next = CH_IDLE;
                        cnt_next   = '0;
                    end
                end else begin
                    case (state_reg)
                        CH_DLY: begin
                            if (cnt_reg <= CNT_ONE) begin
                                if (ld_width != '0) begin
                                    state_next = CH_PLS;
                                    cnt_next   = ld_width;
                                end else begin
                                    state_next = CH_IDLE;
                                    cnt_next   = '0;
                                end
                            end else begin
                                cnt_next = cnt_reg - CNT_ONE;
                            end
                        end
                        CH_PLS: begin
                            if (cnt_reg <= CNT_ONE) begin
                                state_next = CH_IDLE;
                                cnt_next   = '0;
                            end else begin
                                cnt_next = cnt_reg - CNT_ONE;
                            end
                        end
                        default: begin
                            state_next = CH_IDLE;
                            cnt_next   = '0;
                        end
                    endcase
                end
            end

            assign ch_active_next[gi] = (state_next != CH_IDLE);
            assign TRG_PLS[gi]        = pls_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ptmch_trg_seq.sv
// ---------------------------------------------------------------------------
// tb_ptmch_trg_seq
// Directed bench for ptmch_trg_seq. SPI frames are driven at CLK160M/8.
// A negedge monitor logs TRG_PLS/BUSY per cycle; sequences are checked
// against a timeline computed from the bench's own copy of the settings,
// anchored on the observed BUSY rising edge (cycle t+1).
// ---------------------------------------------------------------------------
module tb_ptmch_trg_seq;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 16;
    localparam int HIST   = 40000;

    logic              CLK160M = 1'b0;
    logic              RESET;
    logic              SPI_CS;
    logic              SPI_CLK;
    logic              SPI_MOSI;
    logic [NUM_CH-1:0] TRG_PLS;
    logic              BUSY;
    logic              FRAME_ERR;

    always #5 CLK160M = ~CLK160M;

    ptmch_trg_seq #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .CLK160M   (CLK160M),
        .RESET     (RESET),
        .SPI_CS    (SPI_CS),
        .SPI_CLK   (SPI_CLK),
        .SPI_MOSI  (SPI_MOSI),
        .TRG_PLS   (TRG_PLS),
        .BUSY      (BUSY),
        .FRAME_ERR (FRAME_ERR)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int err_cnt = 0;
    int last_sclk_cyc = 0;

    logic [NUM_CH-1:0] trg_hist  [HIST];
    logic              busy_hist [HIST];

    // Bench copy of the programmed settings
    int                m_dly [NUM_CH];
    int                m_wid [NUM_CH];
    logic [NUM_CH-1:0] m_en;
    int                m_per;
    bit                m_rep;

    always @(negedge CLK160M) begin
        if (cyc < HIST) begin
            trg_hist[cyc]  = TRG_PLS;
            busy_hist[cyc] = BUSY;
        end
        if (FRAME_ERR === 1'b1) err_cnt++;
        cyc++;
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK160M);
        #2;
    endtask

    task automatic wait_cyc(input int k);
        while (cyc <= k) @(posedge CLK160M);
    endtask

    task automatic spi_frame(input logic [31:0] w, input int nbits, input bit lower, input bit raise_cs);
        if (lower) begin
            SPI_CS = 1'b0;
            repeat (4) step();
        end
        for (int i = 0; i < nbits; i++) begin
            SPI_MOSI = w[31-i];
            repeat (4) step();
            SPI_CLK = 1'b1;
            last_sclk_cyc = cyc;
            repeat (4) step();
            SPI_CLK = 1'b0;
        end
        if (raise_cs) begin
            repeat (4) step();
            SPI_CS = 1'b1;
            repeat (8) step();
        end
        $display("spi: word=%08h bits=%0d", w, nbits);
    endtask

    task automatic wr(input logic [7:0] opc, input logic [7:0] addr, input logic [15:0] data);
        spi_frame({opc, addr, data}, 32, 1'b1, 1'b1);
    endtask

    function automatic logic [NUM_CH-1:0] exp_trg(input int rel);
        logic [NUM_CH-1:0] v;
        int r;
        v = '0;
        if (rel < 0) return v;
        r = (m_rep && m_per > 0) ? (rel % m_per) : rel;
        for (int ch = 0; ch < NUM_CH; ch++)
            if (m_en[ch] && r >= m_dly[ch] && r < m_dly[ch] + m_wid[ch]) v[ch] = 1'b1;
        return v;
    endfunction

    function automatic logic exp_busy(input int rel);
        int last;
        last = 1;
        if (rel < 0) return 1'b0;
        if (m_rep && m_per > 0) return 1'b1;
        for (int ch = 0; ch < NUM_CH; ch++)
            if (m_en[ch] && m_dly[ch] + m_wid[ch] > last) last = m_dly[ch] + m_wid[ch];
        return (rel < last);
    endfunction

    task automatic find_busy_rise(input string tag, input int from, output int b);
        b = -1;
        for (int k = from; k < cyc && k < HIST; k++)
            if (b < 0 && k > 0 && busy_hist[k] === 1'b1 && busy_hist[k-1] === 1'b0) b = k;
        check_eq({tag, "_busy_rise"}, 32'(b >= 0), 32'd1);
        if (b < 0) b = from;
    endtask

    task automatic check_seq(input string tag, input int b, input int lo, input int hi);
        wait_cyc(b + hi);
        for (int k = b + lo; k <= b + hi; k++) begin
            check_eq($sformatf("%s_trg@%0d", tag, k - b), 32'(trg_hist[k]), 32'(exp_trg(k - b)));
            check_eq($sformatf("%s_busy@%0d", tag, k - b), 32'(busy_hist[k]), 32'(exp_busy(k - b)));
        end
    endtask

    task automatic fire(input string tag, output int b, output int lat);
        int s;
        s = cyc;
        wr(8'h10, 8'h00, 16'h0000);
        find_busy_rise(tag, s, b);
        lat = b - last_sclk_cyc;
    endtask

    task automatic model_clear();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_dly[ch] = 0;
            m_wid[ch] = 0;
        end
        m_en  = '0;
        m_per = 0;
        m_rep = 1'b0;
    endtask

    initial begin
        int b, b2, lat, lat_f, a, la, err0;

        RESET    = 1'b1;
        SPI_CS   = 1'b1;
        SPI_CLK  = 1'b0;
        SPI_MOSI = 1'b0;
        model_clear();
        repeat (5) step();
        RESET = 1'b0;
        @(negedge CLK160M);
        check_eq("rst_trg",   32'(TRG_PLS),   32'd0);
        check_eq("rst_busy",  32'(BUSY),      32'd0);
        check_eq("rst_ferr",  32'(FRAME_ERR), 32'd0);
        repeat (4) step();

        // Single channel: DELAY=5, WIDTH=3 -> pulse t+6..t+8, BUSY low at t+9
        wr(8'h01, 8'h00, 16'd5);
        wr(8'h02, 8'h00, 16'd3);
        wr(8'h03, 8'h00, 16'h0001);
        m_dly[0] = 5; m_wid[0] = 3; m_en = 8'h01;
        fire("single", b, lat);
        check_eq("fire_lat_window", 32'(lat >= 2 && lat <= 6), 32'd1);
        check_seq("single", b, -1, 12);

        // Staggered: all channels, DELAY[n]=n, WIDTH[n]=2
        for (int n = 0; n < NUM_CH; n++) begin
            wr(8'h01, 8'(n), 16'(n));
            wr(8'h02, 8'(n), 16'd2);
            m_dly[n] = n; m_wid[n] = 2;
        end
        wr(8'h03, 8'h00, 16'h00FF);
        m_en = 8'hFF;
        fire("stagger", b, lat);
        check_seq("stagger", b, -1, 12);

        // Truncated frame (17 bits) -> one FRAME_ERR cycle, config untouched;
        // an empty CS pulse raises no error.
        err0 = err_cnt;
        spi_frame({8'h01, 8'h00, 16'h0001}, 17, 1'b1, 1'b1);
        check_eq("ferr_17bits", 32'(err_cnt - err0), 32'd1);
        err0 = err_cnt;
        SPI_CS = 1'b0;
        repeat (8) step();
        SPI_CS = 1'b1;
        repeat (8) step();
        check_eq("ferr_0bits", 32'(err_cnt - err0), 32'd0);
        fire("cfg_kept", b, lat);
        check_seq("cfg_kept", b, -1, 12);

        // FIRE during BUSY ignored; DELAY write mid-sequence only for next FIRE
        wr(8'h03, 8'h00, 16'h0001);
        wr(8'h01, 8'h00, 16'd600);
        wr(8'h02, 8'h00, 16'd10);
        m_en = 8'h01; m_dly[0] = 600; m_wid[0] = 10;
        fire("long", b, lat);
        wr(8'h10, 8'h00, 16'h0000);
        wr(8'h01, 8'h00, 16'd9);
        check_seq("long", b, -1, 612);
        m_dly[0] = 9;
        fire("shadow", b2, lat);
        check_seq("shadow", b2, -1, 21);

        // Repeat mode, PERIOD=20, then ABORT
        wr(8'h05, 8'h00, 16'h0001);
        wr(8'h04, 8'h00, 16'd20);
        wr(8'h01, 8'h00, 16'd2);
        wr(8'h02, 8'h00, 16'd4);
        m_rep = 1'b1; m_per = 20; m_dly[0] = 2; m_wid[0] = 4;
        fire("repeat", b, lat_f);
        wr(8'h11, 8'h00, 16'h0000);
        la = last_sclk_cyc;
        a = -1;
        for (int k = b + 1; k < cyc && k < HIST; k++)
            if (a < 0 && busy_hist[k] === 1'b0) a = k;
        check_eq("abort_found", 32'(a >= 0), 32'd1);
        if (a < 0) a = b + 1;
        check_eq("repeat_span", 32'((a - b) >= 100), 32'd1);
        check_eq("abort_lat_eq_fire", 32'(a - la), 32'(lat_f));
        check_seq("repeat", b, -1, a - 1 - b);
        wait_cyc(a + 25);
        for (int k = a; k <= a + 25; k++)
            check_eq($sformatf("abort_idle@%0d", k - a), 32'({trg_hist[k], busy_hist[k]}), 32'd0);

        // Reset mid-pulse and mid-frame
        wr(8'h05, 8'h00, 16'h0000);
        wr(8'h02, 8'h00, 16'd1000);
        m_rep = 1'b0; m_wid[0] = 1000;
        fire("pre_rst", b, lat);
        err0 = err_cnt;
        spi_frame(32'hA5A5A5A5, 10, 1'b1, 1'b0);
        @(negedge CLK160M);
        check_eq("pre_rst_pulse", 32'(TRG_PLS[0]), 32'd1);
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        @(negedge CLK160M);
        check_eq("midrst_trg",  32'(TRG_PLS),   32'd0);
        check_eq("midrst_busy", 32'(BUSY),      32'd0);
        check_eq("midrst_ferr", 32'(FRAME_ERR), 32'd0);
        spi_frame(32'hFFFF0000, 5, 1'b0, 1'b1);
        check_eq("postrst_no_ferr", 32'(err_cnt - err0), 32'd0);
        check_eq("postrst_busy", 32'(BUSY), 32'd0);
        model_clear();
        wr(8'h01, 8'h01, 16'd3);
        wr(8'h01, 8'h09, 16'd7);   // out-of-range address, must not alias
        wr(8'h02, 8'h01, 16'd2);
        wr(8'h7F, 8'h01, 16'hFFFF); // unknown opcode
        wr(8'h03, 8'h00, 16'h0002);
        m_dly[1] = 3; m_wid[1] = 2; m_en = 8'h02;
        fire("post_rst", b, lat);
        check_seq("post_rst", b, -1, 8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
